// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync polarity and scanout types.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned CNT_W = 10;

  // Both syncs are active-low.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    PENDING,
    ACK
  } scanout_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with sync, active and vblank-start decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT = H_ACTIVE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_ACT = V_ACTIVE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixel_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             line_end_c,
  output logic             active_c,
  output logic             hsync_c,
  output logic             vsync_c,
  output logic             vblank_start_c
);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACT + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACT + H_FP + H_SW);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACT + V_FP + V_SW + V_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACT - 1);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACT + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACT + V_FP + V_SW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  assign line_end_c = (h_cnt == H_LAST);
  assign active_c   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync_c    = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync_c    = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // Strobe on the tick that moves the counters onto the first vblank line.
  assign vblank_start_c = pixel_en && line_end_c && (v_cnt == V_ACT_LAST);

endmodule

// File: rtl/framebuffer_scanout.sv
// Scans the displayed half of a double-buffered frame buffer out to VGA with
// integer upscaling, and swaps buffers at vblank start on drawer request.
module framebuffer_scanout
  import vga_pkg::*;
#(
  parameter int unsigned BUFFER_WIDTH      = 160,
  parameter int unsigned BUFFER_HEIGHT     = 120,
  parameter int unsigned BUFFER_DATA_WIDTH = 12,
  parameter int unsigned BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int unsigned SCALE             = 4,
  parameter int unsigned H_FRONT_PORCH     = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC_WIDTH      = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK_PORCH      = vga_pkg::H_BACK,
  parameter int unsigned V_FRONT_PORCH     = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC_WIDTH      = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK_PORCH      = vga_pkg::V_BACK
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pixel_en,
  input  logic                         frame_done,
  output logic                         draw_ack,
  output logic                         buffer_select,
  output logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] read_data,
  output logic                         vga_hsync,
  output logic                         vga_vsync,
  output logic [3:0]                   vga_r,
  output logic [3:0]                   vga_g,
  output logic [3:0]                   vga_b
);

  localparam int unsigned SCALE_SHIFT = $clog2(SCALE);
  localparam int unsigned H_ACT       = BUFFER_WIDTH * SCALE;
  localparam int unsigned V_ACT       = BUFFER_HEIGHT * SCALE;
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACT + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACT - 1);
  localparam logic [BUFFER_ADDR_WIDTH-1:0] ROW_STEP = BUFFER_ADDR_WIDTH'(BUFFER_WIDTH);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             line_end_c;
  logic             active_c;
  logic             hsync_c;
  logic             vsync_c;
  logic             vblank_start_c;

  vga_timing #(
    .H_ACT (H_ACT),
    .H_FP  (H_FRONT_PORCH),
    .H_SW  (H_SYNC_WIDTH),
    .H_BP  (H_BACK_PORCH),
    .V_ACT (V_ACT),
    .V_FP  (V_FRONT_PORCH),
    .V_SW  (V_SYNC_WIDTH),
    .V_BP  (V_BACK_PORCH)
  ) u_timing (
    .clk            (clk),
    .rst            (rst),
    .pixel_en       (pixel_en),
    .h_cnt          (h_cnt),
    .v_cnt          (v_cnt),
    .line_end_c     (line_end_c),
    .active_c       (active_c),
    .hsync_c        (hsync_c),
    .vsync_c        (vsync_c),
    .vblank_start_c (vblank_start_c)
  );

  logic [BUFFER_ADDR_WIDTH-1:0] row_base;
  logic                         active_d;
  logic                         hsync_d;
  logic                         vsync_d;
  logic                         row_last_c;
  rgb444_t                      rgb;

  assign row_last_c = (v_cnt[SCALE_SHIFT-1:0] == '1) && (v_cnt < V_ACT_LAST);

  // Address stage: row_base tracks (v_cnt/SCALE)*BUFFER_WIDTH by accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base  <= '0;
      read_addr <= '0;
      active_d  <= 1'b0;
      hsync_d   <= ~SYNC_ACTIVE;
      vsync_d   <= ~SYNC_ACTIVE;
    end else if (pixel_en) begin
      active_d <= active_c;
      hsync_d  <= hsync_c;
      vsync_d  <= vsync_c;
      if (active_c) begin
        read_addr <= row_base + BUFFER_ADDR_WIDTH'(h_cnt >> SCALE_SHIFT);
      end
      if (line_end_c) begin
        if (v_cnt == V_LAST) begin
          row_base <= '0;
        end else if (row_last_c) begin
          row_base <= row_base + ROW_STEP;
        end
      end
    end
  end

  // Output stage: read_data has settled by the next tick; sync rides alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= '0;
      vga_hsync <= ~SYNC_ACTIVE;
      vga_vsync <= ~SYNC_ACTIVE;
    end else if (pixel_en) begin
      rgb       <= active_d ? rgb444_t'(read_data[11:0]) : '0;
      vga_hsync <= hsync_d;
      vga_vsync <= vsync_d;
    end
  end

  assign vga_r = rgb.r;
  assign vga_g = rgb.g;
  assign vga_b = rgb.b;

  scanout_state_t state;
  scanout_state_t state_next;
  logic           select_next;
  logic           ack_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_FRAME;
      buffer_select <= 1'b0;
      draw_ack      <= 1'b0;
    end else begin
      state         <= state_next;
      buffer_select <= select_next;
      draw_ack      <= ack_next;
    end
  end

  // Swap only on entry to vblank so the displayed buffer is stable while active.
  always_comb begin
    state_next  = state;
    select_next = buffer_select;
    ack_next    = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (frame_done) state_next = PENDING;
      end
      PENDING: begin
        if (vblank_start_c) begin
          state_next  = ACK;
          select_next = ~buffer_select;
          ack_next    = 1'b1;
        end
      end
      ACK:     state_next = WAIT_FRAME;
      default: state_next = WAIT_FRAME;
    endcase
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout on a reduced 8x4-buffer geometry
// (32x16 active, 40x20 total) so many frames fit in a short run.
module tb_framebuffer_scanout;

  localparam int unsigned BW    = 8;
  localparam int unsigned BH    = 4;
  localparam int unsigned SC    = 4;
  localparam int unsigned DW    = 12;
  localparam int unsigned AW    = $clog2(BW * BH);
  localparam int unsigned HA    = BW * SC;
  localparam int unsigned HF    = 2;
  localparam int unsigned HS    = 4;
  localparam int unsigned HB    = 2;
  localparam int unsigned HT    = HA + HF + HS + HB;
  localparam int unsigned VA    = BH * SC;
  localparam int unsigned VF    = 1;
  localparam int unsigned VS    = 2;
  localparam int unsigned VB    = 1;
  localparam int unsigned VT    = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst;
  logic          pixel_en;
  logic          frame_done;
  logic          draw_ack;
  logic          buffer_select;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          vga_hsync;
  logic          vga_vsync;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .BUFFER_WIDTH      (BW),
    .BUFFER_HEIGHT     (BH),
    .BUFFER_DATA_WIDTH (DW),
    .BUFFER_ADDR_WIDTH (AW),
    .SCALE             (SC),
    .H_FRONT_PORCH     (HF),
    .H_SYNC_WIDTH      (HS),
    .H_BACK_PORCH      (HB),
    .V_FRONT_PORCH     (VF),
    .V_SYNC_WIDTH      (VS),
    .V_BACK_PORCH      (VB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_en      (pixel_en),
    .frame_done    (frame_done),
    .draw_ack      (draw_ack),
    .buffer_select (buffer_select),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          hs;
    logic          vs;
    logic [11:0]   rgb;
    logic          ack;
    logic          sel;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   ack_clks = 0;

  int            mh;
  int            mv;
  int            raise_cnt;
  bit            m_pend;
  bit            m_sel;
  bit            auto_mode;
  logic [AW-1:0] m_addr;
  logic          p_hs;
  logic          p_vs;
  logic [11:0]   p_rgb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Buffer memory: data is the low 12 bits of the address, one clk late.
  initial begin
    read_data = '0;
    forever begin
      @(posedge clk);
      #1 read_data = DW'(read_addr);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (draw_ack === 1'b1) ack_clks++;
    end
  end

  // Monitor: each pixel tick updates the registered outputs; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (pixel_en === 1'b1 && rst === 1'b0) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("read_addr", 32'(read_addr), 32'(e.addr));
          chk("hsync", 32'(vga_hsync), 32'(e.hs));
          chk("vsync", 32'(vga_vsync), 32'(e.vs));
          chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
          chk("draw_ack", 32'(draw_ack), 32'(e.ack));
          chk("buffer_select", 32'(buffer_select), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mh        = 0;
    mv        = 0;
    raise_cnt = 0;
    m_pend    = 1'b0;
    m_sel     = 1'b0;
    m_addr    = '0;
    p_hs      = 1'b1;
    p_vs      = 1'b1;
    p_rgb     = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_draw_ack"}, 32'(draw_ack), 32'd0);
    chk({tag, "_buffer_select"}, 32'(buffer_select), 32'd0);
    chk({tag, "_read_addr"}, 32'(read_addr), 32'd0);
    chk({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
    chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
  endtask

  // One pixel tick: queue what the outputs must show afterwards, then pulse pixel_en.
  task automatic tick();
    exp_t e;
    bit   act;
    bit   ent;
    if (raise_cnt != 0) begin
      raise_cnt--;
      if (raise_cnt == 0) frame_done = 1'b1;
    end
    if (!m_pend && frame_done) m_pend = 1'b1;
    act = (mh < int'(HA)) && (mv < int'(VA));
    if (act) m_addr = AW'((mv / SC) * BW + mh / SC);
    if (mh == 5 && mv == 9)   m_addr = 5'd17;
    if (mh == 31 && mv == 15) m_addr = 5'd31;
    ent = m_pend && (mh == int'(HT) - 1) && (mv == int'(VA) - 1);
    if (ent) begin
      m_pend = 1'b0;
      m_sel  = ~m_sel;
    end
    e.addr = m_addr;
    e.hs   = p_hs;
    e.vs   = p_vs;
    e.rgb  = p_rgb;
    e.ack  = ent;
    e.sel  = m_sel;
    sb.push_back(e);
    p_hs  = !(mh >= int'(HA + HF) && mh < int'(HA + HF + HS));
    p_vs  = !(mv >= int'(VA + VF) && mv < int'(VA + VF + VS));
    p_rgb = act ? 12'(m_addr) : 12'h000;
    if (mh == 5 && mv == 9) p_rgb = 12'h011;
    if (mh == int'(HT) - 1) begin
      mh = 0;
      mv = (mv == int'(VT) - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    @(negedge clk);
    pixel_en = 1'b1;
    @(negedge clk);
    pixel_en = 1'b0;
    if (ent) begin
      frame_done = 1'b0;
      if (auto_mode) raise_cnt = 3;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int h, input int v);
    for (int i = 0; i <= int'(FRAME); i++) begin
      if (mh == h && mv == v) return;
      tick();
    end
    chk("run_until_bound", 32'd0, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    pixel_en   = 1'b0;
    frame_done = 1'b0;
    auto_mode  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Request during active region: one ack at the first vblank entry.
    run_until(0, 6);
    frame_done = 1'b1;
    run_ticks(FRAME);
    chk("acks_after_swap", 32'(ack_clks), 32'd1);
    chk("select_after_swap", 32'(buffer_select), 32'd1);
    run_ticks(FRAME);
    chk("acks_idle_frame", 32'(ack_clks), 32'd1);

    // Mid-line async reset with a swap pending: everything clears, request dropped.
    frame_done = 1'b1;
    run_until(20, 10);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midline");
    @(negedge clk);
    frame_done = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_until(0, 17);
    chk("acks_after_reset", 32'(ack_clks), 32'd1);

    // Request after the swap point waits for the next frame.
    run_until(0, 18);
    frame_done = 1'b1;
    run_until(0, 0);
    chk("acks_late_same_vblank", 32'(ack_clks), 32'd1);
    run_until(0, 17);
    chk("acks_late_next_frame", 32'(ack_clks), 32'd2);

    // Back-to-back requests: one ack per frame over four frames.
    auto_mode  = 1'b1;
    frame_done = 1'b1;
    run_ticks(4 * FRAME);
    chk("acks_back_to_back", 32'(ack_clks), 32'd6);
    chk("select_back_to_back", 32'(buffer_select), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
Display-side reader of the double-buffered 160x120 frame buffer. Generates 640x480@60 VGA timing and upscales each buffer pixel 4x4. Completes the frame_done/draw_ack handshake with the drawing pipeline by swapping buffers only at vblank start, so the drawer never writes the buffer being scanned out.

Parameters:
BUFFER_WIDTH, 160, buffer pixels per line
BUFFER_HEIGHT, 120, buffer lines
BUFFER_DATA_WIDTH, 12, RGB444 pixel width
BUFFER_ADDR_WIDTH, $clog2(BUFFER_WIDTH*BUFFER_HEIGHT), read address width
SCALE, 4, screen pixels per buffer pixel in each axis (BUFFER_WIDTH*SCALE must equal H_ACTIVE)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pixel_en  in  1  pixel-clock tick; one clk wide; at least 2 clk apart
frame_done  in  1  drawer has finished the back buffer; held high until draw_ack
draw_ack  out  1  one-clk pulse: swap done, drawer may start the next frame
buffer_select  out  1  buffer being displayed; drawer writes the other one
read_addr  out  BUFFER_ADDR_WIDTH  address into the displayed buffer
read_data  in  BUFFER_DATA_WIDTH  buffer data, valid 1 clk after read_addr
vga_hsync  out  1  active-low
vga_vsync  out  1  active-low
vga_r, vga_g, vga_b  out  4 each  colour outputs; 0 outside the active area

Behaviour:
- Reset (async, rst=1): h_cnt=0, v_cnt=0, read_addr=0, buffer_select=0, draw_ack=0, hsync=vsync=1, rgb=0, FSM=WAIT_FRAME.
- Timing, advanced only on pixel_en:
  - H: 640 active, 16 front porch, 96 sync, 48 back porch; total 800.
  - V: 480 active, 10 front porch, 2 sync, 33 back porch; total 525.
  - h_cnt wraps 799->0 and increments v_cnt; v_cnt wraps 524->0.
  - Sync is low for h in [656,751] and v in [490,491].
- Address stage, registered on pixel_en:
  - read_addr = (v_cnt/SCALE)*BUFFER_WIDTH + h_cnt/SCALE when active, else held.
  - Implement with a row-base register that adds BUFFER_WIDTH every SCALE lines. No multiplier.
- Output stage, registered on the next pixel_en:
  - {r,g,b} = read_data[11:8], [7:4], [3:0] when the delayed active flag is set, else 0.
  - hsync/vsync pass through the same 2-tick delay, so colour and sync stay aligned.
  - Total latency from counter to pins: 2 pixel_en ticks.
- Swap FSM:
  - WAIT_FRAME: frame_done=1 -> PENDING.
  - PENDING: on the pixel_en where the counters enter (h=0, v=480), toggle buffer_select -> ACK.
  - ACK: draw_ack=1 for exactly this clk -> WAIT_FRAME.
- draw_ack is registered, with no combinational path from frame_done.
- frame_done arriving during vblank, after the swap point, waits for the next frame's vblank start. At most one swap per frame.
- frame_done is sampled only in WAIT_FRAME. Because the drawer drops it the cycle after draw_ack, a held level cannot produce a double ack.
- buffer_select never changes during the active region.
- Reset mid-frame: everything returns to reset values immediately; any pending swap is discarded.

Decomposition:
- vga_pkg:
  - H/V active, porch, sync and total localparams.
  - Sync polarity.
  - scanout_state_t enum {WAIT_FRAME, PENDING, ACK}.
  - rgb444_t struct.
- Sub-module vga_timing: counters, sync, active flag, vblank_start strobe. Inputs clk, rst, pixel_en.
- framebuffer_scanout holds the address pipeline and the swap FSM.

Test Plan:
- Reset check: assert rst mid-line at h=300 -> all outputs at reset values, including hsync=vsync=1; after release, h_cnt restarts at 0.
- Line/frame timing: run 2 frames at pixel_en every 4 clk -> hsync low for exactly 96 ticks per 800, vsync low for 2 lines per 525, rgb=0 outside 640x480.
- Address mapping:
  - At (h=5, v=9), read_addr = 321.
  - At (639, 479), read_addr = 19199.
  - With read_data = address[11:0], the pixel at (5, 9) appears 2 ticks later as rgb = {4'h1, 4'h4, 4'h1}.
- Swap: frame_done raised at v=100 -> draw_ack high for exactly 1 clk at vblank start (v=480, h=0); buffer_select 0->1; no toggle during the active region.
- Late request: frame_done raised at v=500 -> no ack in that vblank; ack at v=480 of the next frame.
- Back-to-back: drawer model re-asserts frame_done 10 clk after each ack -> exactly one ack and one toggle per frame over 4 frames.
